mac_table: RTL and testbench

Stores destination-MAC → outport/flag entries in a `P_TABLE_DEPTH`-entry table. The table is written through the update port, which is driven by the MAC-table init stage and later by learning logic. It is read through a lookup request/response handshake used by the forwarding path. Lookups use a sequential scan FSM, one entry per cycle. Updates use a single-cycle parallel match and insert.

---
 rtl/mac_table.sv | 196 +++++++++++++++++++
 tb/tb_mac_table.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_table.sv
// MAC forwarding table: parallel match/insert on update,
// sequential one-entry-per-cycle scan on lookup.
module mac_table #(
  parameter int P_OUTPORT_WIDTH = 4,
  parameter int P_TABLE_DEPTH   = 16,
  parameter int P_CNT_WIDTH     = $clog2(P_TABLE_DEPTH) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [47:0]                i_update_dest_mac,
  input  logic [P_OUTPORT_WIDTH-1:0] i_update_outport,
  input  logic                       i_update_flag,
  input  logic                       i_update_valid,
  input  logic                       i_clear,
  output logic                       o_update_drop,
  input  logic [47:0]                i_lookup_mac,
  input  logic                       i_lookup_valid,
  output logic                       o_lookup_ready,
  output logic [P_OUTPORT_WIDTH-1:0] o_result_outport,
  output logic                       o_result_flag,
  output logic                       o_result_hit,
  output logic                       o_result_valid,
  output logic [P_CNT_WIDTH-1:0]     o_entry_count
);

  localparam int D  = P_TABLE_DEPTH;
  localparam int IW = $clog2(P_TABLE_DEPTH);
  localparam int OW = P_OUTPORT_WIDTH;
  localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = P_CNT_WIDTH'(D);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_t;

  logic [D-1:0]   vld_q, vld_d;
  logic [47:0]    mac_q  [D];
  logic [47:0]    mac_d  [D];
  logic [OW-1:0]  port_q [D];
  logic [OW-1:0]  port_d [D];
  logic [D-1:0]   flag_q, flag_d;

  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   drop_q, drop_d;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [47:0]    key_q, key_d;
  logic           hit_q, hit_d;
  logic [OW-1:0]  rport_q, rport_d;
  logic           rflag_q, rflag_d;

  logic           m_any, f_any, upd_ok;
  logic [IW-1:0]  m_idx, f_idx;
  logic           scan_hit;

  // Parallel search: existing MAC match and lowest free slot
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    f_any = 1'b0;
    f_idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        f_any = 1'b1;
        f_idx = IW'(i);
      end
    end
    for (int i = 0; i < D; i++) begin
      if (vld_q[i] && mac_q[i] == i_update_dest_mac) begin
        m_any = 1'b1;
        m_idx = IW'(i);
      end
    end
  end

  // Table write, clear, entry count and drop pulse
  always_comb begin
    vld_d  = vld_q;
    mac_d  = mac_q;
    port_d = port_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    drop_d = 1'b0;
    upd_ok = i_update_valid && (i_update_dest_mac != 48'h0);
    if (i_clear) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (upd_ok) begin
      if (m_any) begin
        port_d[m_idx] = i_update_outport;
        flag_d[m_idx] = i_update_flag;
      end else if (f_any) begin
        vld_d[f_idx]  = 1'b1;
        mac_d[f_idx]  = i_update_dest_mac;
        port_d[f_idx] = i_update_outport;
        flag_d[f_idx] = i_update_flag;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Table storage registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < D; i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      for (int i = 0; i < D; i++) begin
        mac_q[i]  <= mac_d[i];
        port_q[i] <= port_d[i];
      end
    end
  end

  // Key 0 can never match; entry contents are live during the scan
  assign scan_hit = (key_q != 48'h0) && vld_q[idx_q] &&
                    (mac_q[idx_q] == key_q);

  // Lookup FSM next state and result loading
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    hit_d   = hit_q;
    rport_d = rport_q;
    rflag_d = rflag_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_lookup_valid) begin
          key_d   = i_lookup_mac;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_hit) begin
          hit_d   = 1'b1;
          rport_d = port_q[idx_q];
          rflag_d = flag_q[idx_q];
          state_d = S_RESP;
        end else if (idx_q == IW'(D - 1)) begin
          hit_d   = 1'b0;
          rport_d = '0;
          rflag_d = 1'b0;
          state_d = S_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lookup FSM registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      rport_q <= '0;
      rflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      rport_q <= rport_d;
      rflag_q <= rflag_d;
    end
  end

  assign o_update_drop    = drop_q;
  assign o_entry_count    = cnt_q;
  assign o_lookup_ready   = (state_q == S_IDLE);
  assign o_result_valid   = (state_q == S_RESP);
  assign o_result_hit     = hit_q;
  assign o_result_outport = rport_q;
  assign o_result_flag    = rflag_q;

endmodule

// File: tb/tb_mac_table.sv
// Testbench for mac_table: directed scenarios plus random
// update/lookup traffic against a slot-ordered table model.
module tb_mac_table;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [47:0] upd_mac;
  logic [3:0]  upd_port;
  logic        upd_flag;
  logic        upd_valid;
  logic        clr;
  logic        drop;
  logic [47:0] lk_mac;
  logic        lk_valid;
  logic        lk_ready;
  logic [3:0]  res_port;
  logic        res_flag;
  logic        res_hit;
  logic        res_valid;
  logic [4:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] m_mac  [$];
  logic [3:0]  m_port [$];
  logic        m_flag [$];

  mac_table dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_update_dest_mac (upd_mac),
    .i_update_outport  (upd_port),
    .i_update_flag     (upd_flag),
    .i_update_valid    (upd_valid),
    .i_clear           (clr),
    .o_update_drop     (drop),
    .i_lookup_mac      (lk_mac),
    .i_lookup_valid    (lk_valid),
    .o_lookup_ready    (lk_ready),
    .o_result_outport  (res_port),
    .o_result_flag     (res_flag),
    .o_result_hit      (res_hit),
    .o_result_valid    (res_valid),
    .o_entry_count     (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    m_mac.delete();
    m_port.delete();
    m_flag.delete();
  endtask

  task automatic model_update(input logic [47:0] mac,
                              input logic [3:0] port,
                              input logic flag,
                              output bit exp_drop);
    bit found;
    exp_drop = 1'b0;
    found = 1'b0;
    if (mac == 48'h0) return;
    foreach (m_mac[i]) begin
      if (m_mac[i] == mac) begin
        m_port[i] = port;
        m_flag[i] = flag;
        found = 1'b1;
      end
    end
    if (!found) begin
      if (m_mac.size() < DEPTH) begin
        m_mac.push_back(mac);
        m_port.push_back(port);
        m_flag.push_back(flag);
      end else begin
        exp_drop = 1'b1;
      end
    end
  endtask

  task automatic do_update(input logic [47:0] mac,
                           input logic [3:0] port,
                           input logic flag);
    bit ed;
    upd_mac = mac;
    upd_port = port;
    upd_flag = flag;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    model_update(mac, port, flag, ed);
    n_checks++;
    if (drop !== ed) begin
      n_fail++;
      $display("FAIL upd_drop mac=%0h got=%b exp=%b", mac, drop, ed);
    end
    n_checks++;
    if (cnt !== 5'(m_mac.size())) begin
      n_fail++;
      $display("FAIL upd_count mac=%0h got=%0d exp=%0d",
               mac, cnt, m_mac.size());
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    n_checks++;
    if (cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL clear_count got=%0d exp=0", cnt);
    end
  endtask

  task automatic do_lookup(input logic [47:0] mac,
                           input bit ins_en,
                           input int ins_at,
                           input logic [47:0] ins_mac,
                           input logic [3:0] ins_port,
                           input logic ins_flag);
    int k, n, exp_lat, s;
    logic [3:0] ep;
    logic ef, ehit;
    bit got, rbad, ed;
    k = -1;
    ep = 4'h0;
    ef = 1'b0;
    if (mac != 48'h0) begin
      foreach (m_mac[i]) begin
        if (k < 0 && m_mac[i] == mac) begin
          k = i;
          ep = m_port[i];
          ef = m_flag[i];
        end
      end
    end
    if (k < 0 && ins_en && ins_mac == mac && mac != 48'h0 &&
        m_mac.size() < DEPTH) begin
      s = m_mac.size();
      if (s >= ins_at + 1) begin
        k = s;
        ep = ins_port;
        ef = ins_flag;
      end
    end
    ehit = (k >= 0);
    exp_lat = ehit ? k + 1 : DEPTH;
    n_checks++;
    if (lk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lk_ready_idle got=%b exp=1", lk_ready);
    end
    lk_mac = mac;
    lk_valid = 1'b1;
    @(negedge clk);
    lk_valid = 1'b0;
    lk_mac = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    n = 0;
    got = 1'b0;
    rbad = 1'b0;
    while (n < 40) begin
      if (lk_ready !== 1'b0) rbad = 1'b1;
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      upd_valid = ins_en && (n == ins_at);
      if (upd_valid) begin
        upd_mac = ins_mac;
        upd_port = ins_port;
        upd_flag = ins_flag;
      end
      @(negedge clk);
      n++;
    end
    upd_valid = 1'b0;
    if (ins_en) model_update(ins_mac, ins_port, ins_flag, ed);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL lk_timeout mac=%0h no result in 40 cycles", mac);
    end
    n_checks++;
    if (n != exp_lat) begin
      n_fail++;
      $display("FAIL lk_latency mac=%0h got=%0d exp=%0d",
               mac, n, exp_lat);
    end
    n_checks++;
    if (res_hit !== ehit || res_port !== ep || res_flag !== ef) begin
      n_fail++;
      $display("FAIL lk_result mac=%0h got=%b/%0h/%b exp=%b/%0h/%b",
               mac, res_hit, res_port, res_flag, ehit, ep, ef);
    end
    n_checks++;
    if (rbad) begin
      n_fail++;
      $display("FAIL lk_ready_busy mac=%0h got=1 exp=0", mac);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || lk_ready !== 1'b1 || res_hit !== ehit) begin
      n_fail++;
      $display("FAIL lk_after mac=%0h valid=%b ready=%b hit=%b exp 0/1/%b",
               mac, res_valid, lk_ready, res_hit, ehit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (res_valid !== 1'b0 || res_hit !== 1'b0 || res_port !== 4'h0 ||
        res_flag !== 1'b0 || drop !== 1'b0 || cnt !== 5'd0 ||
        lk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s v=%b h=%b p=%0h f=%b d=%b c=%0d r=%b exp 0000001",
               tag, res_valid, res_hit, res_port, res_flag, drop, cnt,
               lk_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_fill_overwrite();
    for (int m = 1; m <= 16; m++)
      do_update(48'(m), 4'((m - 1) >> 1), 1'b1);
    do_update(48'd1, 4'd0, 1'b0);
    do_update(48'd2, 4'd1, 1'b0);
    do_lookup(48'd2, 1'b0, 0, 48'd0, 4'd0, 1'b0);
  endtask

  task automatic test_full_drop();
    do_update(48'd17, 4'd3, 1'b1);
    @(negedge clk);
    n_checks++;
    if (drop !== 1'b0 || cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL drop_once drop=%b cnt=%0d exp 0/16", drop, cnt);
    end
    do_lookup(48'd17, 1'b0, 0, 48'd0, 4'd0, 1'b0);
    do_lookup(48'd16, 1'b0, 0, 48'd0, 4'd0, 1'b0);
  endtask

  task automatic test_duplicate();
    do_clear();
    do_update(48'd5, 4'd2, 1'b0);
    do_update(48'd5, 4'd7, 1'b1);
    do_lookup(48'd5, 1'b0, 0, 48'd0, 4'd0, 1'b0);
  endtask

  task automatic test_scan_race();
    do_clear();
    for (int m = 20; m < 24; m++) do_update(48'(m), 4'(m), 1'b0);
    do_lookup(48'd9, 1'b1, 0, 48'd9, 4'd6, 1'b1);
    do_clear();
    do_update(48'd30, 4'd1, 1'b0);
    do_update(48'd31, 4'd2, 1'b0);
    do_lookup(48'd9, 1'b1, 5, 48'd9, 4'd6, 1'b1);
    do_lookup(48'd9, 1'b0, 0, 48'd0, 4'd0, 1'b0);
  endtask

  task automatic test_clear_wins();
    do_update(48'd3, 4'd4, 1'b1);
    clr = 1'b1;
    upd_mac = 48'd3;
    upd_port = 4'd5;
    upd_flag = 1'b0;
    upd_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    upd_valid = 1'b0;
    model_clear();
    n_checks++;
    if (cnt !== 5'd0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins cnt=%0d drop=%b exp 0/0", cnt, drop);
    end
    do_lookup(48'd3, 1'b0, 0, 48'd0, 4'd0, 1'b0);
    do_update(48'd8, 4'd1, 1'b0);
    do_update(48'd0, 4'd2, 1'b1);
    do_lookup(48'd0, 1'b0, 0, 48'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    do_update(48'd40, 4'd1, 1'b1);
    lk_mac = 48'd99;
    lk_valid = 1'b1;
    @(negedge clk);
    lk_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_scan");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || lk_ready !== 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_abort got strobe/busy exp idle");
    end
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_clear();
      repeat (24)
        do_update(48'($urandom_range(0, 22)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
      repeat (8)
        do_lookup(48'($urandom_range(0, 22)), 1'b0, 0, 48'd0, 4'd0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    upd_mac = '0;
    upd_port = '0;
    upd_flag = 1'b0;
    upd_valid = 1'b0;
    clr = 1'b0;
    lk_mac = '0;
    lk_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_overwrite();
    test_full_drop();
    test_duplicate();
    test_scan_race();
    test_clear_wins();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
